// File: rtl/fpnew_inorder_issue_pkg.sv
// Shared types for the in-order FPU issue / reorder front end.
package fpnew_inorder_issue_pkg;

    // IEEE exception flags returned alongside every FPU result
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_inorder_issue.sv
// Tags core operations, issues them to an FPU back-end and returns the
// possibly out-of-order results to the core strictly in issue order.
module fpnew_inorder_issue
    import fpnew_inorder_issue_pkg::*;
#(
    parameter int unsigned Width       = 32,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned OpInfoWidth = 16,
    parameter int unsigned UserWidth   = 8,
    parameter int unsigned Depth       = 4,
    localparam int unsigned IdxWidth   = $clog2(Depth)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [NumOperands*Width-1:0] req_operands_i,
    input  logic [OpInfoWidth-1:0]       req_opinfo_i,
    input  logic [UserWidth-1:0]         req_user_i,
    output logic                         fpu_valid_o,
    input  logic                         fpu_ready_i,
    output logic [NumOperands*Width-1:0] fpu_operands_o,
    output logic [OpInfoWidth-1:0]       fpu_opinfo_o,
    output logic [IdxWidth-1:0]          fpu_tag_o,
    output logic                         fpu_flush_o,
    input  logic                         fpu_out_valid_i,
    output logic                         fpu_out_ready_o,
    input  logic [Width-1:0]             fpu_result_i,
    input  status_t                      fpu_status_i,
    input  logic [IdxWidth-1:0]          fpu_tag_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [Width-1:0]             rsp_result_o,
    output status_t                      rsp_status_o,
    output logic [UserWidth-1:0]         rsp_user_o,
    output logic                         busy_o
);

    typedef struct packed {
        logic                 alloc;
        logic                 done;
        logic [UserWidth-1:0] user;
        logic [Width-1:0]     result;
        status_t              status;
    } entry_t;

    entry_t              r_rob [Depth];
    logic [IdxWidth:0]   r_wrPtr;
    logic [IdxWidth:0]   r_rdPtr;

    logic [IdxWidth-1:0] w_wrIdx;
    logic [IdxWidth-1:0] w_rdIdx;
    logic                w_full;
    logic                w_empty;
    logic                w_issue;
    logic                w_resultWr;
    logic                w_retire;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    assign w_wrIdx = r_wrPtr[IdxWidth-1:0];
    assign w_rdIdx = r_rdPtr[IdxWidth-1:0];
    assign w_full  = (w_wrIdx == w_rdIdx) && (r_wrPtr[IdxWidth] != r_rdPtr[IdxWidth]);
    assign w_empty = (r_wrPtr == r_rdPtr);

    assign fpu_valid_o    = req_valid_i & ~w_full & ~flush_i;
    assign req_ready_o    = fpu_ready_i & ~w_full & ~flush_i;
    assign fpu_operands_o = req_operands_i;
    assign fpu_opinfo_o   = req_opinfo_i;
    assign fpu_tag_o      = w_wrIdx;
    assign fpu_flush_o    = flush_i;

    // Space is reserved at issue, so results can always be accepted
    assign fpu_out_ready_o = 1'b1;

    assign w_issue    = fpu_valid_o & fpu_ready_i;
    assign w_resultWr = fpu_out_valid_i & ~flush_i & r_rob[fpu_tag_i].alloc;

    assign rsp_valid_o  = r_rob[w_rdIdx].alloc & r_rob[w_rdIdx].done;
    assign rsp_result_o = r_rob[w_rdIdx].result;
    assign rsp_status_o = r_rob[w_rdIdx].status;
    assign rsp_user_o   = r_rob[w_rdIdx].user;
    assign w_retire     = rsp_valid_o & rsp_ready_i;

    assign busy_o = ~w_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_rob[i] <= '0;
            end
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_rob[i].alloc <= 1'b0;
                r_rob[i].done  <= 1'b0;
            end
        end else begin
            // Issue, result write and retire always target distinct entries
            if (w_issue) begin
                r_rob[w_wrIdx].alloc <= 1'b1;
                r_rob[w_wrIdx].done  <= 1'b0;
                r_rob[w_wrIdx].user  <= req_user_i;
                r_wrPtr              <= r_wrPtr + {{IdxWidth{1'b0}}, 1'b1};
            end
            if (w_resultWr) begin
                r_rob[fpu_tag_i].done   <= 1'b1;
                r_rob[fpu_tag_i].result <= fpu_result_i;
                r_rob[fpu_tag_i].status <= fpu_status_i;
            end
            if (w_retire) begin
                r_rob[w_rdIdx].alloc <= 1'b0;
                r_rob[w_rdIdx].done  <= 1'b0;
                r_rdPtr              <= r_rdPtr + {{IdxWidth{1'b0}}, 1'b1};
            end
        end
    end

    // A returning tag must name a live entry that has not completed yet
    a_resultAllocated: assert property (@(posedge clk_i) disable iff (rst_i)
        (fpu_out_valid_i && !flush_i) |-> r_rob[fpu_tag_i].alloc);
    a_resultNotDone: assert property (@(posedge clk_i) disable iff (rst_i)
        (fpu_out_valid_i && !flush_i) |-> !r_rob[fpu_tag_i].done);

endmodule

// File: doc/fpnew_inorder_issue.md
Name: fpnew_inorder_issue

Overview:
- Initiator-side companion to the FPU operation-group blocks.
- Accepts operations from the core, assigns each a reorder tag, and issues it to an FPU back-end with a valid/ready handshake.
- Collects results, which may return out of order across format slices, in a reorder buffer.
- Returns results to the core strictly in issue order, carrying the caller's user field.

Parameters:
- Width, 32, operand/result width in bits.
- NumOperands, 3, operands per operation.
- OpInfoWidth, 16, opaque packed op descriptor (op, op_mod, rnd, fmts) passed through untouched.
- UserWidth, 8, caller tag returned with each response.
- Depth, 4, reorder-buffer entries; power of two, >= 2.
- IdxWidth (localparam), $clog2(Depth), width of the FPU tag.

Ports:
- clk_i in 1 clock
- rst_i in 1 asynchronous active-high reset
- flush_i in 1 discard all outstanding operations
- req_valid_i in 1 core request valid
- req_ready_o out 1 core request ready
- req_operands_i in NumOperands*Width operands
- req_opinfo_i in OpInfoWidth op descriptor
- req_user_i in UserWidth caller tag
- fpu_valid_o out 1 issue valid
- fpu_ready_i in 1 issue ready
- fpu_operands_o out NumOperands*Width operands to FPU
- fpu_opinfo_o out OpInfoWidth descriptor to FPU
- fpu_tag_o out IdxWidth ROB index
- fpu_flush_o out 1 flush forwarded to FPU
- fpu_out_valid_i in 1 FPU result valid
- fpu_out_ready_o out 1 FPU result ready
- fpu_result_i in Width result
- fpu_status_i in 5 fpnew_pkg::status_t flags
- fpu_tag_i in IdxWidth ROB index of result
- rsp_valid_o out 1 in-order response valid
- rsp_ready_i in 1 response ready
- rsp_result_o out Width result
- rsp_status_o out 5 status flags
- rsp_user_o out UserWidth caller tag
- busy_o out 1 any entry allocated

Behaviour:
- Reset: asynchronous on rst_i high.
  - wr_ptr = rd_ptr = 0 (IdxWidth+1 bits, MSB is the wrap bit).
  - All entries: alloc=0, done=0.
  - Outputs: rsp_valid_o=0, busy_o=0; req_ready_o and fpu_valid_o are 0 unless req_valid_i/fpu_ready_i are high with the ROB empty.
- Full = (wr_ptr index == rd_ptr index) && wrap bits differ. Empty = pointers equal.
- Issue path is combinational, zero added latency:
  - fpu_valid_o = req_valid_i & ~full & ~flush_i.
  - req_ready_o = fpu_ready_i & ~full & ~flush_i.
  - fpu_operands_o, fpu_opinfo_o follow the req_* inputs.
  - fpu_tag_o = wr_ptr index.
- Issue handshake (fpu_valid_o & fpu_ready_i):
  - Entry[wr_ptr] gets alloc=1, done=0, user=req_user_i.
  - wr_ptr increments, wrapping modulo 2*Depth.
- Result path:
  - fpu_out_ready_o = 1 constantly; space is reserved at issue.
  - On fpu_out_valid_i & ~flush_i: entry[fpu_tag_i] gets done=1, result, status.
  - A result whose tag has alloc=0 is dropped; an assertion fires in simulation.
  - A result for an entry already done=1 triggers an assertion.
- Response:
  - rsp_valid_o = entry[rd_ptr].alloc & done.
  - rsp_* fields are driven from entry storage.
  - Minimum latency: a result accepted in cycle N is visible at rsp_valid_o in cycle N+1.
  - On rsp_valid_o & rsp_ready_i: entry[rd_ptr] is cleared (alloc=0, done=0) and rd_ptr increments.
  - rsp_valid_o, once high, holds with stable data until accepted.
- Simultaneous events:
  - Issue, result write and retire in the same cycle are legal and touch distinct entries.
  - When full, retire in cycle N frees space for issue only in N+1; there is no same-cycle bypass.
  - A result for the head entry in cycle N retires no earlier than N+1.
- Flush:
  - fpu_flush_o = flush_i.
  - On flush_i: all alloc/done are cleared and wr_ptr = rd_ptr = 0 at the next edge.
  - Issue is blocked in the flush cycle and results arriving that cycle are dropped.
  - The FPU discards in-flight operations on its flush, so no stale tags return.
- Reset mid-operation: all state is lost and no response is produced for outstanding entries.
- busy_o = ~empty (registered-state derived).

Decomposition:
- No new fpnew_pkg additions beyond reusing fpnew_pkg::status_t.
- The ROB entry struct (alloc, done, user, result, status) is local to the module.
- Single module; the storage is a flop array. No sub-module is warranted.

Test Plan:
- Single op: issue user=0x5A; return result 0x3F800000, status 0 in tag 0 after 3 cycles; rsp_valid_o rises the next cycle with user 0x5A, then busy_o=0.
- Out-of-order return: issue users 1,2,3; results arrive for tags 2,0,1; responses emerge as users 1,2,3 in order, with none valid before tag 0 arrives.
- Full: issue 4 ops with no results returned; req_ready_o=0 on the 5th while fpu_ready_i=1. Retire one (after its result arrives); req_ready_o returns to 1 one cycle later.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with the head done; rsp_* stay stable and issue continues until full.
- Pointer wrap: stream 20 ops with random result delays and random rsp_ready_i; all 20 responses arrive in order with matching user/result.
- Flush and reset: flush with 3 outstanding and a result arriving in the same cycle; no response is produced, pointers are 0, fpu_flush_o pulses 1 cycle, busy_o=0 next cycle. Assert rst_i mid-stream; rsp_valid_o and busy_o go 0 immediately (async).
